// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron: state encoding,
// heading codes, random-heading fallbacks and parameter defaults.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    REFRACT = 2'd2
  } state_t;

  localparam logic [3:0] HEAD_N = 4'b1000;
  localparam logic [3:0] HEAD_E = 4'b0100;
  localparam logic [3:0] HEAD_S = 4'b0010;
  localparam logic [3:0] HEAD_W = 4'b0001;

  localparam logic [3:0] HEAD_RAND_A = 4'b1010;
  localparam logic [3:0] HEAD_RAND_B = 4'b0101;

  localparam int DEF_PW       = 8;
  localparam int DEF_THRESH   = 8;
  localparam int DEF_W_DIRECT = 4;
  localparam int DEF_W_GLANCE = 1;
  localparam int DEF_LEAK     = 1;
  localparam int DEF_REFRAC   = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lif_neuron_lfsr.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) supplying the random
// firing heading; only the top bit is consumed by the neuron.
module lif_neuron_lfsr
  import lif_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic msb
);

  logic [15:0] q;

  always_ff @(posedge clk) begin
    if (reset)
      q <= LFSR_SEED;
    else if (en)
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

  assign msb = q[15];

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weighted direction hits from four
// neighbours, fires a one-cycle heading pulse at threshold, then rests.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int PW       = DEF_PW,
  parameter int THRESH   = DEF_THRESH,
  parameter int W_DIRECT = DEF_W_DIRECT,
  parameter int W_GLANCE = DEF_W_GLANCE,
  parameter int LEAK     = DEF_LEAK,
  parameter int REFRAC   = DEF_REFRAC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [3:0]    in1,
  input  logic [3:0]    in2,
  input  logic [3:0]    in3,
  input  logic [3:0]    in4,
  output logic [3:0]    out,
  output logic          fire,
  output logic [PW-1:0] potential,
  output logic          refractory
);

  localparam int CW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int SW = PW + 16;
  localparam logic [PW-1:0] PMAX = '1;
  localparam logic [PW-1:0] TH   = PW'(THRESH);
  localparam logic [PW-1:0] LK   = PW'(LEAK);

  state_t        state, state_nx;
  logic [PW-1:0] pot_nx;
  logic [3:0]    head, head_nx, out_nx;
  logic          fire_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rnd_bit;

  logic          hit_e, hit_w, hit_n, hit_s, any_hit;
  logic [3:0]    hit_head, fire_head;
  logic [2:0]    nd;
  logic [3:0]    ng;
  logic [SW-1:0] sum_wide;
  logic [PW-1:0] sum, leaked;

  lif_neuron_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .msb   (rnd_bit)
  );

  // Opposing direct hits cancel each other before anything is counted.
  always_comb begin
    hit_e = in1[2] & ~in3[0];
    hit_w = in3[0] & ~in1[2];
    hit_n = in2[3] & ~in4[1];
    hit_s = in4[1] & ~in2[3];
    nd = 3'(hit_e) + 3'(hit_w) + 3'(hit_n) + 3'(hit_s);
    ng = 4'(in1[1]) + 4'(in1[3]) + 4'(in2[0]) + 4'(in2[2])
       + 4'(in3[1]) + 4'(in3[3]) + 4'(in4[0]) + 4'(in4[2]);
    any_hit = (nd != 3'd0) || (ng != 4'd0);
    hit_head = hit_e ? HEAD_E : hit_w ? HEAD_W : hit_n ? HEAD_N : hit_s ? HEAD_S : 4'b0000;
    sum_wide = SW'(potential) + SW'(W_DIRECT) * SW'(nd) + SW'(W_GLANCE) * SW'(ng);
    sum = (sum_wide > SW'(PMAX)) ? PMAX : sum_wide[PW-1:0];
    leaked = (potential > LK) ? potential - LK : '0;
    fire_head = (nd != 3'd0)   ? hit_head :
                (head != 4'd0) ? head     :
                rnd_bit        ? HEAD_RAND_A : HEAD_RAND_B;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else if (en)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_hit && sum >= TH) state_nx = FIRE;
      FIRE:    state_nx = (REFRAC == 0) ? IDLE : REFRACT;
      REFRACT: if (cnt <= CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered datapath; FIRE and REFRACT ignore the inputs.
  always_comb begin
    pot_nx  = potential;
    head_nx = head;
    cnt_nx  = cnt;
    out_nx  = out;
    fire_nx = fire;
    case (state)
      IDLE: begin
        if (state_nx == FIRE) begin
          pot_nx  = '0;
          head_nx = 4'b0000;
          out_nx  = fire_head;
          fire_nx = 1'b1;
        end else begin
          pot_nx = any_hit ? sum : leaked;
          if (nd != 3'd0) head_nx = hit_head;
        end
      end
      FIRE: begin
        out_nx  = 4'b0000;
        fire_nx = 1'b0;
        cnt_nx  = CW'(REFRAC);
      end
      REFRACT: begin
        pot_nx = '0;
        cnt_nx = (cnt != '0) ? cnt - CW'(1) : '0;
      end
      default: begin
        pot_nx  = '0;
        out_nx  = 4'b0000;
        fire_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      potential <= '0;
      head      <= 4'b0000;
      cnt       <= '0;
      out       <= 4'b0000;
      fire      <= 1'b0;
    end else if (en) begin
      potential <= pot_nx;
      head      <= head_nx;
      cnt       <= cnt_nx;
      out       <= out_nx;
      fire      <= fire_nx;
    end
  end

  assign refractory = (state == REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: a cycle-level arithmetic model is compared
// on every falling edge, and directed scenarios pin key values by hand.
module tb_lif_neuron;

  localparam int T_THRESH   = 8;
  localparam int T_W_DIRECT = 4;
  localparam int T_W_GLANCE = 1;
  localparam int T_LEAK     = 1;
  localparam int T_REFRAC   = 3;
  localparam int T_PMAX     = 255;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] in1, in2, in3, in4;
  logic [3:0] out;
  logic       fire;
  logic [7:0] potential;
  logic       refractory;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  lif_neuron dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .in4        (in4),
    .out        (out),
    .fire       (fire),
    .potential  (potential),
    .refractory (refractory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: potential as a plain integer, a firing flag, and the
  // number of rest cycles still owed.
  int          m_pot;
  int          m_rest;
  logic [3:0]  m_head;
  logic [3:0]  m_out;
  logic        m_fire;
  logic [15:0] m_lfsr;

  task automatic integrateModel(input logic rbit);
    bit e, w, n, s;
    int nd, ng, total;
    logic [3:0] hit;
    e = in1[2]; w = in3[0]; n = in2[3]; s = in4[1];
    if (e && w) begin e = 0; w = 0; end
    if (n && s) begin n = 0; s = 0; end
    nd = int'(e) + int'(w) + int'(n) + int'(s);
    ng = int'(in1[1]) + int'(in1[3]) + int'(in2[0]) + int'(in2[2])
       + int'(in3[1]) + int'(in3[3]) + int'(in4[0]) + int'(in4[2]);
    hit = e ? 4'b0100 : w ? 4'b0001 : n ? 4'b1000 : s ? 4'b0010 : 4'b0000;
    total = m_pot + T_W_DIRECT * nd + T_W_GLANCE * ng;
    if (total > T_PMAX) total = T_PMAX;
    if (nd + ng == 0) begin
      m_pot = (m_pot > T_LEAK) ? m_pot - T_LEAK : 0;
    end else if (total >= T_THRESH) begin
      m_fire = 1'b1;
      if (hit != 4'b0000)         m_out = hit;
      else if (m_head != 4'b0000) m_out = m_head;
      else                        m_out = rbit ? 4'b1010 : 4'b0101;
      m_pot  = 0;
      m_head = 4'b0000;
    end else begin
      m_pot = total;
      if (hit != 4'b0000) m_head = hit;
    end
  endtask

  always @(posedge clk) begin
    logic [15:0] r;
    if (reset) begin
      m_pot  = 0;
      m_rest = 0;
      m_head = 4'b0000;
      m_out  = 4'b0000;
      m_fire = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      r = m_lfsr;
      m_lfsr = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
      if (en) begin
        if (m_fire) begin
          m_fire = 1'b0;
          m_out  = 4'b0000;
          m_rest = T_REFRAC;
        end else if (m_rest > 0) begin
          m_rest = m_rest - 1;
        end else begin
          integrateModel(r[15]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_out",        32'(out),        32'(m_out));
      checkOutput("model_fire",       32'(fire),       32'(m_fire));
      checkOutput("model_potential",  32'(potential),  32'(m_pot));
      checkOutput("model_refractory", 32'(refractory), 32'(m_rest > 0));
    end
  end

  task automatic applyStimulus(input logic rst, input logic e,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d,
                               input int n);
    reset = rst; en = e; in1 = a; in2 = b; in3 = c; in4 = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held for two cycles.
    applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    checkOutput("reset_out",        32'(out),        32'h0);
    checkOutput("reset_fire",       32'(fire),       32'h0);
    checkOutput("reset_potential",  32'(potential),  32'h0);
    checkOutput("reset_refractory", 32'(refractory), 32'h0);
    chk_on = 1;

    // Direct hit from in1 fires on the second cycle, then rests three cycles.
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("direct_pot4", 32'(potential), 32'd4);
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("direct_fire", 32'(fire), 32'h1);
    checkOutput("direct_out",  32'(out),  32'b0100);
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("direct_refr1",    32'(refractory), 32'h1);
    checkOutput("direct_out_zero", 32'(out),        32'h0);
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'h0, 4'h0, 2);
    checkOutput("direct_refr3", 32'(refractory), 32'h1);
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("direct_idle", 32'(refractory), 32'h0);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 6);

    // Opposing east/west hits cancel.
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'b0001, 4'h0, 5);
    checkOutput("cancel_pot",  32'(potential), 32'h0);
    checkOutput("cancel_fire", 32'(fire),      32'h0);

    // Two glancing bits per cycle: 2, 4, 6, then a randomly headed fire.
    applyStimulus(0, 1, 4'b1010, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("glance_pot2", 32'(potential), 32'd2);
    applyStimulus(0, 1, 4'b1010, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("glance_pot4", 32'(potential), 32'd4);
    applyStimulus(0, 1, 4'b1010, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("glance_pot6", 32'(potential), 32'd6);
    applyStimulus(0, 1, 4'b1010, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("glance_fire",    32'(fire), 32'h1);
    checkOutput("glance_out_set", 32'(out == 4'b1010 || out == 4'b0101), 32'h1);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 5);

    // One north hit, then leak down to zero and stay there.
    applyStimulus(0, 1, 4'h0, 4'b1000, 4'h0, 4'h0, 1);
    checkOutput("leak_pot4", 32'(potential), 32'd4);
    for (int k = 3; k >= 0; k--) begin
      applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
      checkOutput("leak_step", 32'(potential), 32'(k));
    end
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 3);
    checkOutput("leak_floor", 32'(potential), 32'h0);

    // Reset on the second rest cycle.
    applyStimulus(0, 1, 4'b0100, 4'h0, 4'h0, 4'h0, 2);
    checkOutput("rst_pre_fire", 32'(fire), 32'h1);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    checkOutput("rst_in_refr", 32'(refractory), 32'h1);
    applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("rst_refr_clear", 32'(refractory), 32'h0);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'b0010, 1);
    checkOutput("south_pot4", 32'(potential), 32'd4);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'b0010, 1);
    checkOutput("south_fire", 32'(fire), 32'h1);
    checkOutput("south_out",  32'(out),  32'b0010);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4);

    // Enable low freezes potential and a pending fire pulse.
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'b0010, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 4'b0010, 1);
      checkOutput("freeze_pot", 32'(potential), 32'd4);
    end
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'b0010, 1);
    checkOutput("freeze_fire", 32'(fire), 32'h1);
    applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    checkOutput("hold_fire", 32'(fire), 32'h1);
    checkOutput("hold_out",  32'(out),  32'b0010);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("release_fire", 32'(fire),       32'h0);
    checkOutput("release_refr", 32'(refractory), 32'h1);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4);

    // Random heading again after the frozen stretch (lfsr kept running).
    applyStimulus(0, 1, 4'b1010, 4'h0, 4'h0, 4'h0, 4);
    checkOutput("glance2_fire", 32'(fire), 32'h1);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 5);

    // Reset during the fire cycle.
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'b0010, 2);
    checkOutput("midfire_fire", 32'(fire), 32'h1);
    applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    checkOutput("midfire_rst_fire", 32'(fire), 32'h0);
    checkOutput("midfire_rst_out",  32'(out),  32'h0);
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 3);
    checkOutput("midfire_idle", 32'(refractory), 32'h0);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
